// File: rtl/mem_access_stage.sv
// Memory stage of the RV64 pipeline. It takes an EX/MEM entry and, for loads
// and stores, drives one data-bus transaction. Load data is aligned and then
// extended. The stage produces a registered MEM/WB entry.
// Ports:
//   clk, reset                  clock and synchronous active-low reset
//   in_*                        EX/MEM entry with valid/ready handshake
//   dreq_*                      data bus request, held stable while BUSY
//   dresp_*                     data bus completion and raw read data
//   out_*                       MEM/WB entry with valid/ready handshake
//
// state | meaning
// IDLE  | no bus transaction; may accept an entry when the output slot frees
// BUSY  | aligned load/store latched; dreq_valid high until dresp_data_ok
module mem_access_stage #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_alu_result,
   input  logic [XLEN-1:0]   in_store_data,
   input  logic [1:0]        in_mem_op,
   input  logic [1:0]        in_mem_size,
   input  logic              in_mem_unsigned,
   input  logic [4:0]        in_reg_dest_addr,
   input  logic              in_reg_write_enable,
   input  logic [31:0]       in_inst,
   input  logic [ADDR_W-1:0] in_inst_pc,
   output logic              dreq_valid,
   output logic [ADDR_W-1:0] dreq_addr,
   output logic [1:0]        dreq_size,
   output logic [7:0]        dreq_strobe,
   output logic [XLEN-1:0]   dreq_data,
   input  logic              dresp_data_ok,
   input  logic [XLEN-1:0]   dresp_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_reg_write_data,
   output logic [4:0]        out_reg_dest_addr,
   output logic              out_reg_write_enable,
   output logic [31:0]       out_inst,
   output logic [ADDR_W-1:0] out_inst_pc,
   output logic              out_misalign
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     sdata_q, sdata_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic                store_q, store_d;
   logic [4:0]          rd_q, rd_d;
   logic                we_q, we_d;
   logic [31:0]         inst_q, inst_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;

   logic                ov_q, ov_d;
   logic [XLEN-1:0]     owd_q, owd_d;
   logic [4:0]          ord_q, ord_d;
   logic                owe_q, owe_d;
   logic [31:0]         oinst_q, oinst_d;
   logic [ADDR_W-1:0]   opc_q, opc_d;
   logic                omis_q, omis_d;

   logic                is_mem, misalign, accept;
   logic [7:0]          size_mask;
   logic [XLEN-1:0]     rd_shift, load_val;

   assign in_ready = (state_q == IDLE) && (!ov_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mem   = (in_mem_op == 2'b01) || (in_mem_op == 2'b10);

   always_comb begin
      misalign = 1'b0;
      case (in_mem_size)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = in_alu_result[0];
         2'd2:    misalign = |in_alu_result[1:0];
         default: misalign = |in_alu_result[2:0];
      endcase
   end

   always_comb begin
      size_mask = 8'hFF;
      case (size_q)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   // Read data arrives 8-byte aligned; bring the addressed lane down to bit 0.
   assign rd_shift = dresp_data >> {addr_q[2:0], 3'b000};

   always_comb begin
      load_val = rd_shift;
      case (size_q)
         2'd0:    load_val = {{(XLEN-8){!uns_q && rd_shift[7]}}, rd_shift[7:0]};
         2'd1:    load_val = {{(XLEN-16){!uns_q && rd_shift[15]}}, rd_shift[15:0]};
         2'd2:    load_val = {{(XLEN-32){!uns_q && rd_shift[31]}}, rd_shift[31:0]};
         default: load_val = rd_shift;
      endcase
   end

   assign dreq_valid  = (state_q == BUSY);
   assign dreq_addr   = addr_q;
   assign dreq_size   = size_q;
   assign dreq_strobe = store_q ? (size_mask << addr_q[2:0]) : 8'h00;
   assign dreq_data   = store_q ? (sdata_q << {addr_q[2:0], 3'b000}) : '0;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      store_d = store_q;
      rd_d    = rd_q;
      we_d    = we_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      ov_d    = ov_q && !out_ready;
      owd_d   = owd_q;
      ord_d   = ord_q;
      owe_d   = owe_q;
      oinst_d = oinst_q;
      opc_d   = opc_q;
      omis_d  = omis_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!is_mem || misalign) begin
                  ov_d    = 1'b1;
                  ord_d   = in_reg_dest_addr;
                  oinst_d = in_inst;
                  opc_d   = in_inst_pc;
                  omis_d  = is_mem;
                  owe_d   = is_mem ? 1'b0 : in_reg_write_enable;
                  owd_d   = is_mem ? '0 : in_alu_result;
               end else begin
                  state_d = BUSY;
                  addr_d  = in_alu_result[ADDR_W-1:0];
                  sdata_d = in_store_data;
                  size_d  = in_mem_size;
                  uns_d   = in_mem_unsigned;
                  store_d = (in_mem_op == 2'b10);
                  rd_d    = in_reg_dest_addr;
                  we_d    = in_reg_write_enable;
                  inst_d  = in_inst;
                  pc_d    = in_inst_pc;
               end
            end
         end
         BUSY: begin
            // The output slot was freed when this entry was accepted.
            if (dresp_data_ok) begin
               state_d = IDLE;
               ov_d    = 1'b1;
               owd_d   = store_q ? '0 : load_val;
               ord_d   = rd_q;
               owe_d   = we_q;
               oinst_d = inst_q;
               opc_d   = pc_q;
               omis_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         sdata_q <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         store_q <= 1'b0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         inst_q  <= '0;
         pc_q    <= '0;
         ov_q    <= 1'b0;
         owd_q   <= '0;
         ord_q   <= '0;
         owe_q   <= 1'b0;
         oinst_q <= '0;
         opc_q   <= '0;
         omis_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         store_q <= store_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         ov_q    <= ov_d;
         owd_q   <= owd_d;
         ord_q   <= ord_d;
         owe_q   <= owe_d;
         oinst_q <= oinst_d;
         opc_q   <= opc_d;
         omis_q  <= omis_d;
      end
   end

   assign out_valid            = ov_q;
   assign out_reg_write_data   = owd_q;
   assign out_reg_dest_addr    = ord_q;
   assign out_reg_write_enable = owe_q;
   assign out_inst             = oinst_q;
   assign out_inst_pc          = opc_q;
   assign out_misalign         = omis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_alu_result, in_store_data;
   logic [1:0]  in_mem_op, in_mem_size;
   logic        in_mem_unsigned;
   logic [4:0]  in_reg_dest_addr;
   logic        in_reg_write_enable;
   logic [31:0] in_inst;
   logic [63:0] in_inst_pc;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [1:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;
   logic        out_valid, out_ready;
   logic [63:0] out_reg_write_data;
   logic [4:0]  out_reg_dest_addr;
   logic        out_reg_write_enable;
   logic [31:0] out_inst;
   logic [63:0] out_inst_pc;
   logic        out_misalign;

   int total = 0;
   int bad   = 0;
   bit started = 0;

   mem_access_stage #(.XLEN(64), .ADDR_W(64)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_result(in_alu_result), .in_store_data(in_store_data),
      .in_mem_op(in_mem_op), .in_mem_size(in_mem_size),
      .in_mem_unsigned(in_mem_unsigned), .in_reg_dest_addr(in_reg_dest_addr),
      .in_reg_write_enable(in_reg_write_enable), .in_inst(in_inst),
      .in_inst_pc(in_inst_pc),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_reg_write_data(out_reg_write_data),
      .out_reg_dest_addr(out_reg_dest_addr),
      .out_reg_write_enable(out_reg_write_enable),
      .out_inst(out_inst), .out_inst_pc(out_inst_pc),
      .out_misalign(out_misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one pending bus access at most, one output slot.
   bit          m_busy, m_ov;
   logic [63:0] m_data, m_pc;
   logic [4:0]  m_rd;
   logic        m_we, m_mis;
   logic [31:0] m_inst;
   logic [63:0] e_addr, e_sd, e_pc;
   int          e_size;
   bit          e_uns, e_store;
   logic [4:0]  e_rd;
   logic        e_we;
   logic [31:0] e_inst;

   function automatic logic [63:0] lane_mask(input int size);
      int nb = 1 << size;
      return (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
   endfunction

   function automatic logic [63:0] load_value(input logic [63:0] raw, input logic [63:0] addr,
                                              input int size, input bit uns);
      logic [63:0] v, m;
      int nb = 1 << size;
      m = lane_mask(size);
      v = (raw >> (8 * (addr % 8))) & m;
      if (!uns && nb < 8 && v[8*nb-1]) v = v | ~m;
      return v;
   endfunction

   always @(posedge clk) begin
      bit rdy;
      started = 1;
      if (!reset) begin
         m_busy = 0; m_ov = 0; m_data = 0; m_rd = 0; m_we = 0; m_mis = 0;
         m_inst = 0; m_pc = 0;
      end else begin
         rdy = !m_busy && (!m_ov || out_ready);
         if (m_ov && out_ready) m_ov = 0;
         if (rdy && in_valid) begin
            if (in_mem_op == 2'b01 || in_mem_op == 2'b10) begin
               if (in_alu_result % (64'd1 << in_mem_size) != 0) begin
                  m_ov = 1; m_data = 0; m_we = 0; m_mis = 1;
                  m_rd = in_reg_dest_addr; m_inst = in_inst; m_pc = in_inst_pc;
               end else begin
                  m_busy = 1; e_addr = in_alu_result; e_sd = in_store_data;
                  e_size = int'(in_mem_size); e_uns = in_mem_unsigned;
                  e_store = (in_mem_op == 2'b10); e_rd = in_reg_dest_addr;
                  e_we = in_reg_write_enable; e_inst = in_inst; e_pc = in_inst_pc;
               end
            end else begin
               m_ov = 1; m_data = in_alu_result; m_we = in_reg_write_enable; m_mis = 0;
               m_rd = in_reg_dest_addr; m_inst = in_inst; m_pc = in_inst_pc;
            end
         end else if (m_busy && dresp_data_ok) begin
            m_busy = 0; m_ov = 1; m_mis = 0; m_we = e_we; m_rd = e_rd;
            m_inst = e_inst; m_pc = e_pc;
            m_data = e_store ? 64'd0 : load_value(dresp_data, e_addr, e_size, e_uns);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", {63'd0, in_ready}, {63'd0, !m_busy && (!m_ov || out_ready)});
         chk("dreq_valid", {63'd0, dreq_valid}, {63'd0, m_busy});
         if (m_busy) begin
            chk("dreq_addr", dreq_addr, e_addr);
            chk("dreq_size", {62'd0, dreq_size}, 64'(e_size));
            if (e_store) begin
               chk("dreq_strobe", {56'd0, dreq_strobe},
                   (((64'd1 << (1 << e_size)) - 64'd1) << (e_addr % 8)) & 64'hFF);
               chk("dreq_data", dreq_data, e_sd << (8 * (e_addr % 8)));
            end else begin
               chk("dreq_strobe_ld", {56'd0, dreq_strobe}, 64'd0);
            end
         end
         chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
         if (m_ov) begin
            chk("out_data", out_reg_write_data, m_data);
            chk("out_rd", {59'd0, out_reg_dest_addr}, {59'd0, m_rd});
            chk("out_we", {63'd0, out_reg_write_enable}, {63'd0, m_we});
            chk("out_mis", {63'd0, out_misalign}, {63'd0, m_mis});
            chk("out_inst", {32'd0, out_inst}, {32'd0, m_inst});
            chk("out_pc", out_inst_pc, m_pc);
         end
      end
   end

   task automatic drive(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                        input logic [63:0] a, input logic [63:0] sd, input logic [4:0] rd);
      in_valid = 1; in_mem_op = op; in_mem_size = sz; in_mem_unsigned = uns;
      in_alu_result = a; in_store_data = sd; in_reg_dest_addr = rd;
      in_reg_write_enable = 1; in_inst = {a[15:0], 11'd0, rd}; in_inst_pc = 64'h1000 + a;
   endtask

   task automatic wait_accept();
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
      end
      chk("accept_seen", {63'd0, ok}, 64'd1);
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic respond(input int dly, input logic [63:0] d);
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (dreq_valid) ok = 1;
      end
      chk("dreq_seen", {63'd0, ok}, 64'd1);
      for (int i = 0; i < dly; i++) begin
         @(posedge clk); #1;
      end
      dresp_data_ok = 1; dresp_data = d;
      @(posedge clk); #1;
      dresp_data_ok = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0; out_ready = 1; dresp_data_ok = 0; dresp_data = 0;
      drive(2'b00, 2'd0, 0, 0, 0, 0); in_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
      chk("rst_out_data", out_reg_write_data, 64'd0);
      chk("rst_out_we", {63'd0, out_reg_write_enable}, 64'd0);
      chk("rst_out_mis", {63'd0, out_misalign}, 64'd0);
      reset = 1;
      @(posedge clk); #1;

      // ALU pass-through, one cycle latency
      drive(2'b00, 2'd0, 0, 64'h1234, 0, 5'd5);
      wait_accept();
      chk("alu_valid", {63'd0, out_valid}, 64'd1);
      chk("alu_data", out_reg_write_data, 64'h1234);
      chk("alu_rd", {59'd0, out_reg_dest_addr}, 64'd5);

      // signed byte load, response 3 cycles after request
      drive(2'b01, 2'd0, 0, 64'h8000_0003, 0, 5'd6);
      wait_accept();
      chk("lb_busy_ready", {63'd0, in_ready}, 64'd0);
      chk("lb_addr", dreq_addr, 64'h8000_0003);
      respond(3, 64'h0000_0000_8000_0000);
      chk("lb_data", out_reg_write_data, 64'hFFFF_FFFF_FFFF_FF80);

      // halfword store at top lanes, response in the request's first cycle
      drive(2'b10, 2'd1, 0, 64'h1006, 64'hABCD, 5'd0);
      wait_accept();
      chk("sh_strobe", {56'd0, dreq_strobe}, 64'hC0);
      chk("sh_data", dreq_data, 64'hABCD_0000_0000_0000);
      respond(0, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("sh_result", out_reg_write_data, 64'd0);

      // signed word and unsigned half loads
      drive(2'b01, 2'd2, 0, 64'h4004, 0, 5'd7);
      wait_accept();
      respond(1, 64'h8765_4321_0000_0000);
      chk("lw_data", out_reg_write_data, 64'hFFFF_FFFF_8765_4321);
      drive(2'b01, 2'd1, 1, 64'h4002, 0, 5'd8);
      wait_accept();
      respond(0, 64'h0000_0000_F00D_0000);
      chk("lhu_data", out_reg_write_data, 64'h0000_0000_0000_F00D);

      // misaligned word load
      drive(2'b01, 2'd2, 0, 64'h1002, 0, 5'd9);
      wait_accept();
      chk("mis_valid", {63'd0, out_valid}, 64'd1);
      chk("mis_flag", {63'd0, out_misalign}, 64'd1);
      chk("mis_we", {63'd0, out_reg_write_enable}, 64'd0);
      chk("mis_dreq", {63'd0, dreq_valid}, 64'd0);

      // throughput: one ALU entry per cycle
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 2'd0, 0, 64'h100 + 64'(i), 0, 5'(i + 1));
         @(posedge clk); #1;
         chk("thru_data", out_reg_write_data, 64'h100 + 64'(i));
      end
      in_valid = 0;

      // backpressure holds the output and blocks the next load
      drive(2'b00, 2'd0, 0, 64'h55, 0, 5'd10);
      wait_accept();
      out_ready = 0;
      drive(2'b01, 2'd3, 0, 64'h2000, 0, 5'd11);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_dreq", {63'd0, dreq_valid}, 64'd0);
         chk("bp_hold", out_reg_write_data, 64'h55);
      end
      @(posedge clk); #1;
      out_ready = 1;
      wait_accept();
      respond(1, 64'h1122_3344_5566_7788);
      chk("bp_ld_data", out_reg_write_data, 64'h1122_3344_5566_7788);

      // reset during BUSY, stray completion afterwards
      drive(2'b01, 2'd3, 0, 64'h3000, 0, 5'd12);
      wait_accept();
      chk("rm_busy", {63'd0, dreq_valid}, 64'd1);
      reset = 0;
      @(posedge clk); #1;
      reset = 1;
      chk("rm_dreq", {63'd0, dreq_valid}, 64'd0);
      chk("rm_out", {63'd0, out_valid}, 64'd0);
      dresp_data_ok = 1; dresp_data = 64'hDEAD_BEEF;
      @(posedge clk); #1;
      dresp_data_ok = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rm_stray", {63'd0, out_valid}, 64'd0);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory stage of the 5-stage RV64 pipeline. It consumes the EX/MEM register contents and drives loads and stores on the data bus. It aligns and extends load data, and produces the registered MEM/WB contents for write-back. A valid/ready handshake on both sides stalls upstream while a bus transaction is outstanding.

Parameters:
XLEN, 64, data/register width
ADDR_W, 64, address/PC width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  EX/MEM entry valid (inst_signal)
in_ready  out  1  stage can accept an entry this cycle
in_alu_result  in  XLEN  ALU result, used as the effective address for memory ops
in_store_data  in  XLEN  rs2 value for stores
in_mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none
in_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword
in_mem_unsigned  in  1  zero-extend load
in_reg_dest_addr  in  5  destination register
in_reg_write_enable  in  1  write-back enable
in_inst  in  32  instruction word
in_inst_pc  in  ADDR_W  instruction PC
dreq_valid  out  1  data bus request
dreq_addr  out  ADDR_W  request address
dreq_size  out  2  request size
dreq_strobe  out  8  byte write mask; 0 for loads
dreq_data  out  XLEN  lane-aligned store data
dresp_data_ok  in  1  transaction complete
dresp_data  in  XLEN  raw 8-byte-aligned read data
out_valid  out  1  MEM/WB entry valid
out_ready  in  1  write-back accepts entry
out_reg_write_data  out  XLEN  value to write back
out_reg_dest_addr  out  5  passed through
out_reg_write_enable  out  1  passed through; forced 0 on misalign
out_inst  out  32  passed through
out_inst_pc  out  ADDR_W  passed through
out_misalign  out  1  entry had an unaligned memory address

Behaviour:
- FSM states are IDLE and BUSY. The output register (out_*) is separate and holds its value while out_valid && !out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). The stage accepts an entry on in_valid && in_ready.
- Accepted non-memory op: out_* loads on the next edge. Latency is 1 cycle, and out_reg_write_data = in_alu_result.
- Alignment check: an access is misaligned when addr mod (1<<size) != 0.
- Misaligned memory op: no bus request is issued. The output loads in 1 cycle with out_misalign=1, out_reg_write_enable=0 and out_reg_write_data=0.
- Aligned memory op: the stage latches the entry and enters BUSY.
- In BUSY, dreq_valid=1 and all dreq_* fields come from the latched entry. The fields stay stable until dresp_data_ok.
- dreq_addr is the full address.
- Store strobe is ((1<<(1<<size))-1) << addr[2:0]. Store data is store_data << (8*addr[2:0]).
- On dresp_data_ok in BUSY:
  - State returns to IDLE, dreq_valid drops on the next edge, and out_* loads (out_valid=1).
  - Load result: dresp_data >> (8*addr[2:0]), truncated to the access size, then sign- or zero-extended per in_mem_unsigned (dword ignores it).
  - Store result: 0.
- dresp_data_ok in the same cycle dreq_valid first rises is legal, giving a 2-cycle total latency.
- Back-to-back operation: in_ready is high in the cycle after completion only if out_ready is high or out_valid is low.
- dresp_data_ok while in IDLE is ignored.
- Reset (reset==0 at an edge): state=IDLE, out_valid=0, out_misalign=0, out_reg_write_enable=0, and every other out_* = 0. dreq_valid=0 from the first cycle after the reset edge, including mid-transaction. The aborted transaction's late data_ok is ignored.
- Throughput: 1 entry per cycle for non-memory ops when out_ready is held high.

Test Plan:
- ALU pass-through: in_mem_op=00, in_alu_result=0x1234, in_reg_dest_addr=5, in_reg_write_enable=1, out_ready=1. Required: out_valid=1 one cycle later, out_reg_write_data=0x1234, rd=5, dreq_valid never high.
- Signed byte load: addr=0x80000003, size=0, unsigned=0, dresp_data=0x00000000_80000000, data_ok 3 cycles after request. Required: dreq held stable 3 cycles, out_reg_write_data=0xFFFFFFFF_FFFFFF80, in_ready low throughout BUSY.
- Halfword store: addr=0x1006, store_data=0xABCD, size=1. Required: dreq_strobe=0xC0, dreq_data=0xABCD0000_00000000, out_reg_write_data=0 after data_ok.
- Misaligned word load: addr=0x1002, size=2. Required: no dreq_valid, out_misalign=1, out_reg_write_enable=0, latency 1.
- Backpressure: out_ready=0 with out_valid=1. Required: out_* hold, in_ready=0, and a second load is not issued until out_ready=1.
- Reset mid-transaction: reset=0 during BUSY, then dresp_data_ok=1 after release. Required: dreq_valid=0 and out_valid=0 after the reset edge, and no output is produced from the stray data_ok.
